lsu_mem_ctrl: RTL and testbench

- Load/store controller sitting directly upstream of the 16-bit word-addressed data memory.
- Accepts byte-addressed load/store requests from the execute stage over a valid/ready handshake.
- Drives the memory's addr/write_data/write_en/read_en port and captures its combinational read_data.
- Handles byte loads with sign/zero extension, byte stores by read-modify-write, and misalignment errors; returns one single-cycle response per request.

---
 rtl/lsu_pkg.sv | 17 +
 rtl/lsu_byte_lane.sv | 21 ++
 rtl/lsu_mem_ctrl.sv | 143 ++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store controller
package lsu_pkg;

  localparam int LSU_DW = 16;

  localparam logic LSU_SIZE_BYTE = 1'b0;
  localparam logic LSU_SIZE_WORD = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WR,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// rtl/lsu_byte_lane.sv - little-endian byte lane extract/extend and byte merge
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [LSU_DW-1:0] word,
  input  logic              byte_sel,
  input  logic              sign_ext,
  input  logic [7:0]        new_byte,
  output logic [LSU_DW-1:0] load_val,
  output logic [LSU_DW-1:0] merged
);

  logic [7:0] lane;

  always_comb begin
    lane     = byte_sel ? word[15:8] : word[7:0];
    load_val = {{8{sign_ext & lane[7]}}, lane};
    merged   = byte_sel ? {new_byte, word[7:0]} : {word[15:8], new_byte};
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - byte-addressed load/store controller for a 16-bit word memory
// Optional LSU_BOUNDS_CHECK_EN: word addresses >= MEM_DEPTH are rejected like misalignment.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_size,
  input  logic              req_signed,
  input  logic [15:0]       req_addr,
  input  logic [LSU_DW-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [LSU_DW-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [15:0]       mem_addr,
  output logic [LSU_DW-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [LSU_DW-1:0] mem_rdata
);

  lsu_state_t state, state_nx;

  logic              l_sel;
  logic              l_signed;
  logic              l_size;
  logic [7:0]        l_byte;
  logic              req_err;
  logic              misaligned;
  logic              out_of_range;
  logic              we_state;
  logic [LSU_DW-1:0] lane_load;
  logic [LSU_DW-1:0] lane_merged;

  assign misaligned = (req_size == LSU_SIZE_WORD) && req_addr[0];

`ifdef LSU_BOUNDS_CHECK_EN
  assign out_of_range = 32'(req_addr[15:1]) >= MEM_DEPTH;
`else
  localparam int unsigned depth_unused = MEM_DEPTH;
  assign out_of_range = 1'b0;
`endif

  assign req_err = misaligned | out_of_range;

  lsu_byte_lane u_byte_lane (
    .word     (mem_rdata),
    .byte_sel (l_sel),
    .sign_ext (l_signed),
    .new_byte (l_byte),
    .load_val (lane_load),
    .merged   (lane_merged)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_re    = 1'b0;
    we_state  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                      state_nx = RESP;
          else if (!req_we)                 state_nx = LOAD;
          else if (req_size == LSU_SIZE_WORD) state_nx = WR;
          else                              state_nx = RMW_RD;
        end
      end
      LOAD: begin
        mem_re   = 1'b1;
        state_nx = RESP;
      end
      RMW_RD: begin
        mem_re   = 1'b1;
        state_nx = WR;
      end
      WR: begin
        we_state = 1'b1;
        state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Gating with rst_n blocks the write even in the cycle reset is first seen.
  assign mem_we = we_state & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      l_sel     <= 1'b0;
      l_signed  <= 1'b0;
      l_size    <= LSU_SIZE_BYTE;
      l_byte    <= 8'h00;
      mem_addr  <= 16'h0000;
      mem_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            l_sel    <= req_addr[0];
            l_signed <= req_signed;
            l_size   <= req_size;
            l_byte   <= req_wdata[7:0];
            mem_addr <= {1'b0, req_addr[15:1]};
            rsp_err  <= req_err;
            if (req_we && (req_size == LSU_SIZE_WORD) && !req_err)
              mem_wdata <= req_wdata;
          end
        end
        LOAD: begin
          rsp_rdata <= (l_size == LSU_SIZE_WORD) ? mem_rdata : lane_load;
        end
        RMW_RD: begin
          mem_wdata <= lane_merged;
        end
        RESP: begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard bench for lsu_mem_ctrl with a behavioural memory model
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_size;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.MEM_DEPTH(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  function automatic logic [15:0] seed_word(input int i);
    return 16'(i * 40503) ^ 16'h5A5A;
  endfunction

  // Memory attached to the DUT; written only by DUT writes after a one-time fill.
  logic [15:0] mem [0:65535];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= seed_word(i);
      mem[16] <= 16'hA5C3;
      mem_init <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          nre;
    int          nwe;
    logic [15:0] waddr;
    logic [15:0] wdata;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_mem [0:65535];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    int   re_cnt = 0;
    int   we_cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        re_cnt = 0;
        we_cnt = 0;
      end else begin
        if (mem_re || mem_we) begin
          chk("re_we_excl", 32'(mem_re & mem_we), 32'd0);
          if (sb.size() == 0) begin
            chk("stray_access", 32'({mem_re, mem_we}), 32'd0);
          end else begin
            chk("mem_addr", 32'(mem_addr), 32'(sb[0].waddr));
            if (mem_we) chk("mem_wdata", 32'(mem_wdata), 32'(sb[0].wdata));
          end
          re_cnt += int'(mem_re);
          we_cnt += int'(mem_we);
        end
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            chk("mem_re_cycles", 32'(re_cnt), 32'(e.nre));
            chk("mem_we_cycles", 32'(we_cnt), 32'(e.nwe));
          end
          re_cnt = 0;
          we_cnt = 0;
        end
      end
    end
  endtask

  task automatic issue(input logic we, input logic size, input logic sgn,
                       input logic [15:0] addr, input logic [15:0] wdata);
    exp_t        e;
    logic [15:0] wa;
    logic [15:0] w;
    logic [7:0]  b;
    logic        bad;
    int          sh;
    int          t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", 32'(req_ready), 32'd1);
    chk("idle_rsp_clear", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);

    wa  = addr >> 1;
    bad = size && addr[0];
`ifdef LSU_BOUNDS_CHECK_EN
    if (wa >= 16'd256) bad = 1'b1;
`endif
    w  = ref_mem[wa];
    sh = addr[0] ? 8 : 0;
    b  = 8'((w >> sh) & 16'h00FF);

    e.rdata = 16'h0000;
    e.err   = bad;
    e.waddr = wa;
    e.wdata = 16'h0000;
    e.acc   = cyc + 1;
    if (bad) begin
      e.lat = 1; e.nre = 0; e.nwe = 0;
    end else if (!we) begin
      e.lat = 2; e.nre = 1; e.nwe = 0;
      if (size)               e.rdata = w;
      else if (sgn && b >= 8'd128) e.rdata = 16'(int'(b) - 256);
      else                    e.rdata = 16'(b);
    end else if (size) begin
      e.lat = 2; e.nre = 0; e.nwe = 1;
      e.wdata = wdata;
      ref_mem[wa] = wdata;
    end else begin
      e.lat = 3; e.nre = 1; e.nwe = 1;
      e.wdata = (w & ~(16'h00FF << sh)) | (16'(wdata[7:0]) << sh);
      ref_mem[wa] = e.wdata;
    end

    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);

    t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("rsp_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_outputs"}, 32'({rsp_valid, rsp_err, mem_we, mem_re}), 32'd0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  initial begin
    int mism;
    for (int i = 0; i < 512; i++) ref_mem[i] = seed_word(i);
    ref_mem[16] = 16'hA5C3;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 1'b0;
    req_signed = 1'b0;
    req_addr   = 16'h0000;
    req_wdata  = 16'h0000;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    issue(1'b0, 1'b0, 1'b1, 16'h0021, 16'h0000);
    issue(1'b0, 1'b0, 1'b0, 16'h0021, 16'h0000);
    issue(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000);
    issue(1'b1, 1'b0, 1'b0, 16'h0020, 16'h005A);
    issue(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    issue(1'b1, 1'b1, 1'b0, 16'h0040, 16'h1234);
    issue(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    issue(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000);
    issue(1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000);
    issue(1'b1, 1'b0, 1'b0, 16'h0007, 16'h1180);
    issue(1'b0, 1'b0, 1'b1, 16'h0007, 16'h0000);

    // Word store to 0x0050 with reset asserted during its write cycle.
    @(negedge clk);
    req_we    = 1'b1;
    req_size  = 1'b1;
    req_addr  = 16'h0050;
    req_wdata = 16'hBEEF;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("post_reset");
    chk("rst_mem_word", 32'(mem[16'h0028]), 32'(ref_mem[16'h0028]));

    for (int n = 0; n < 80; n++) begin
      issue(1'($urandom), 1'($urandom), 1'($urandom),
            16'($urandom_range(0, 255)), 16'($urandom));
    end

    repeat (4) @(negedge clk);
    mism = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("final_mem_contents", 32'(mism), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
